// File: rtl/snes_joy_pkg.sv
// Shared definitions for the SNES pad reader: FSM states and the bit positions
// of the SNES serial report and of the GB joystick vector.
package snes_joy_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        GAP   = 3'd2,
        LOW   = 3'd3,
        HIGH  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // SNES raw report, index = shift order, active-low
    localparam int SNES_B      = 0;
    localparam int SNES_Y      = 1;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_X      = 9;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;
    localparam int SNES_ID_LO  = 12;

    // GB joystick vector, active-high
    localparam int GB_RIGHT  = 0;
    localparam int GB_LEFT   = 1;
    localparam int GB_UP     = 2;
    localparam int GB_DOWN   = 3;
    localparam int GB_A      = 4;
    localparam int GB_B      = 5;
    localparam int GB_SELECT = 6;
    localparam int GB_START  = 7;

    localparam int SNES_BITS = 16;

endpackage

// File: rtl/joy_sync.sv
// Two-flop synchronizer for the asynchronous pad data line; resets to the
// released (high) level so a reset never looks like a pressed button.
module joy_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= 2'b11;
        else       ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/snes_joy_reader.sv
// Polls an SNES pad over latch/clock/data once per poll period and publishes
// the report as the GB core's active-high 8-bit joystick vector.
module snes_joy_reader
    import snes_joy_pkg::*;
#(
    parameter int LATCH_CYC = 50,
    parameter int HALF_CYC  = 25,
    parameter int POLL_CYC  = 69905
) (
    input  logic       clk,
    input  logic       reset,
    output logic       joy_strobe,
    output logic       joy_clock,
    input  logic       joy_data,
    output logic [7:0] joystick,
    output logic       pad_present,
    output logic       frame_done
);

    localparam int PW = $clog2(POLL_CYC);
    localparam int TW = $clog2((LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYC - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYC - 1);

    state_t                 state, state_nxt;
    logic [PW-1:0]          poll_cnt;
    logic [TW-1:0]          tmr;
    logic [4:0]             bit_idx;
    logic [SNES_BITS-1:0]   sr;
    logic                   data_s;
    logic                   half_done;
    logic                   latch_done;
    logic                   sample;

    joy_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (joy_data),
        .q     (data_s)
    );

    // Signature check: ID nibble all ones, and not a floating-low line
    function automatic logic sig_ok(input logic [SNES_BITS-1:0] raw);
        return (raw[SNES_ID_LO +: 4] == 4'hF) && (raw[SNES_R:SNES_B] != '0);
    endfunction

    function automatic logic [7:0] to_gb(input logic [SNES_BITS-1:0] raw);
        logic [7:0] j;
        j = '0;
        // Opposing directions cancel each other out
        j[GB_RIGHT]  = ~raw[SNES_RIGHT] &  raw[SNES_LEFT];
        j[GB_LEFT]   = ~raw[SNES_LEFT]  &  raw[SNES_RIGHT];
        j[GB_UP]     = ~raw[SNES_UP]    &  raw[SNES_DOWN];
        j[GB_DOWN]   = ~raw[SNES_DOWN]  &  raw[SNES_UP];
        j[GB_A]      = ~raw[SNES_A] | ~raw[SNES_X];
        j[GB_B]      = ~raw[SNES_B] | ~raw[SNES_Y];
        j[GB_SELECT] = ~raw[SNES_SELECT];
        j[GB_START]  = ~raw[SNES_START];
        return j;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)                     poll_cnt <= '0;
        else if (poll_cnt == POLL_LAST) poll_cnt <= '0;
        else                           poll_cnt <= poll_cnt + 1'b1;
    end

    // Per-state cycle timer, cleared on every state change
    always_ff @(posedge clk) begin
        if (reset)                                  tmr <= '0;
        else if (state != state_nxt || state == IDLE) tmr <= '0;
        else                                        tmr <= tmr + 1'b1;
    end

    assign half_done  = (tmr == HALF_LAST);
    assign latch_done = (tmr == LATCH_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (poll_cnt == '0) state_nxt = LATCH;
            LATCH:   if (latch_done)     state_nxt = GAP;
            GAP:     if (half_done)      state_nxt = LOW;
            LOW:     if (half_done)      state_nxt = HIGH;
            HIGH:    if (half_done)      state_nxt = bit_idx[4] ? DONE : LOW;
            DONE:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        joy_strobe = 1'b0;
        joy_clock  = 1'b1;
        case (state)
            LATCH:   joy_strobe = 1'b1;
            LOW:     joy_clock  = 1'b0;
            default: ;
        endcase
    end

    // Sample just before the falling clock edge, when the pad's bit is settled
    assign sample = half_done && ((state == GAP) || (state == HIGH && !bit_idx[4]));

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx     <= '0;
            sr          <= '1;
            joystick    <= '0;
            pad_present <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= (state == DONE);
            if (sample) begin
                sr      <= {data_s, sr[SNES_BITS-1:1]};
                bit_idx <= (state == GAP) ? 5'd1 : bit_idx + 5'd1;
            end
            if (state == DONE) begin
                pad_present <= sig_ok(sr);
                joystick    <= sig_ok(sr) ? to_gb(sr) : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_snes_joy_reader.sv
// Directed bench for snes_joy_reader: a behavioural SNES pad answers the
// latch/clock protocol and each scenario task checks timing and button mapping.
module tb_snes_joy_reader;

    localparam int POLL_T = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       joy_strobe, joy_clock, joy_data;
    logic [7:0] joystick;
    logic       pad_present, frame_done;

    logic       reset_def = 1'b1;
    logic       data_def = 1'b1;
    logic       strobe_def, clock_def, pad_present_def, frame_done_def;
    logic [7:0] joystick_def;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snes_joy_reader #(.LATCH_CYC(50), .HALF_CYC(25), .POLL_CYC(POLL_T)) dut (
        .clk         (clk),
        .reset       (reset),
        .joy_strobe  (joy_strobe),
        .joy_clock   (joy_clock),
        .joy_data    (joy_data),
        .joystick    (joystick),
        .pad_present (pad_present),
        .frame_done  (frame_done)
    );

    // Default-parameter instance, used only to measure the real poll period
    snes_joy_reader dut_def (
        .clk         (clk),
        .reset       (reset_def),
        .joy_strobe  (strobe_def),
        .joy_clock   (clock_def),
        .joy_data    (data_def),
        .joystick    (joystick_def),
        .pad_present (pad_present_def),
        .frame_done  (frame_done_def)
    );

    // Pad model: latch on strobe, shift on rising clock, 0 = pressed
    logic [15:0] pad_report = 16'hFFFF;
    logic [15:0] pad_sr = 16'hFFFF;
    bit          pad_attached = 1'b1;

    always @(posedge joy_strobe or posedge joy_clock) begin
        if (joy_strobe) pad_sr <= pad_report;
        else            pad_sr <= {1'b1, pad_sr[15:1]};
    end

    assign joy_data = pad_attached ? pad_sr[0] : 1'b0;

    bit prev_strobe = 1'b0;
    bit prev_sdef = 1'b0;
    int rise_prev = -1, rise_last = -1;
    int def_rise1 = -1, def_rise2 = -1, def_done_cnt = 0;

    always @(negedge clk) begin
        if (joy_strobe && !prev_strobe) begin
            rise_prev = rise_last;
            rise_last = cyc;
        end
        prev_strobe = joy_strobe;
        if (!reset_def) begin
            if (strobe_def && !prev_sdef) begin
                if (def_rise1 < 0)      def_rise1 = cyc;
                else if (def_rise2 < 0) def_rise2 = cyc;
            end
            if (frame_done_def) def_done_cnt++;
        end
        prev_sdef = strobe_def;
    end

    logic [15:0] raws  [7] = '{16'hFEF7, 16'hFDFF, 16'hFFFD, 16'hF3FF, 16'hFF8F, 16'hFF1F, 16'hFFFB};
    logic [7:0]  exps  [7] = '{8'h90,    8'h10,    8'h20,    8'h00,    8'h02,    8'h08,    8'h40};
    string       names [7] = '{"a_start", "x_only", "y_only", "l_r", "up_down_left", "left_right_down", "select"};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int hi, pulses, badlen, low_run, done_c;
        reset = 1'b1; reset_def = 1'b1;
        pad_attached = 1'b1; pad_report = 16'hFFFF;
        repeat (3) tick();
        tests++; if (joy_strobe !== 1'b0) begin fails++; $display("FAIL rst_strobe: got %b want 0", joy_strobe); end
        tests++; if (joy_clock !== 1'b1) begin fails++; $display("FAIL rst_clock: got %b want 1", joy_clock); end
        tests++; if (joystick !== 8'h00) begin fails++; $display("FAIL rst_joystick: got %h want 00", joystick); end
        tests++; if (pad_present !== 1'b0) begin fails++; $display("FAIL rst_present: got %b want 0", pad_present); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", frame_done); end
        reset = 1'b0; reset_def = 1'b0;
        tick();
        tests++; if (joy_strobe !== 1'b1) begin fails++; $display("FAIL strobe_first_cycle: got %b want 1", joy_strobe); end
        hi = 1; pulses = 0; badlen = 0; low_run = 0; done_c = -1;
        for (int c = 2; c <= 1200; c++) begin
            tick();
            if (joy_strobe) hi++;
            if (!joy_clock) low_run++;
            else if (low_run > 0) begin
                pulses++;
                if (low_run != 25) badlen++;
                low_run = 0;
            end
            if (frame_done) begin done_c = c; break; end
        end
        tests++; if (hi != 50) begin fails++; $display("FAIL strobe_len: got %0d want 50", hi); end
        tests++; if (pulses != 16) begin fails++; $display("FAIL clock_pulses: got %0d want 16", pulses); end
        tests++; if (badlen != 0) begin fails++; $display("FAIL clock_low_len: %0d pulses not 25 cycles", badlen); end
        tests++; if (done_c - 1 < 874 || done_c - 1 > 876) begin
            fails++; $display("FAIL frame_len: got %0d want 875+-1", done_c - 1);
        end
        tests++; if (joystick !== 8'h00) begin fails++; $display("FAIL idle_joystick: got %h want 00", joystick); end
        tests++; if (pad_present !== 1'b1) begin fails++; $display("FAIL idle_present: got %b want 1", pad_present); end
    endtask

    task automatic test_buttons();
        bit ok;
        for (int i = 0; i < 7; i++) begin
            pad_report = raws[i];
            ok = 1'b0;
            for (int n = 0; n < 3 * POLL_T; n++) begin
                tick();
                if (frame_done) begin ok = 1'b1; break; end
            end
            tests++;
            if (!ok) begin fails++; $display("FAIL %s_timeout: no frame_done", names[i]); end
            else if (joystick !== exps[i]) begin
                fails++; $display("FAIL %s: got %h want %h", names[i], joystick, exps[i]);
            end
            tests++; if (pad_present !== 1'b1) begin fails++; $display("FAIL %s_present: got %b want 1", names[i], pad_present); end
        end
    endtask

    task automatic test_no_pad();
        bit ok;
        pad_attached = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 3 * POLL_T; n++) begin
            tick();
            if (frame_done) begin ok = 1'b1; break; end
        end
        tests++; if (!ok || joystick !== 8'h00) begin fails++; $display("FAIL nopad_joystick: got %h ok=%b want 00", joystick, ok); end
        tests++; if (pad_present !== 1'b0) begin fails++; $display("FAIL nopad_present: got %b want 0", pad_present); end
        pad_attached = 1'b1;
        pad_report = 16'hFF7F;
        ok = 1'b0;
        for (int n = 0; n < 3 * POLL_T; n++) begin
            tick();
            if (frame_done) begin ok = 1'b1; break; end
        end
        tests++; if (!ok || joystick !== 8'h01) begin fails++; $display("FAIL attach_right: got %h ok=%b want 01", joystick, ok); end
        tests++; if (pad_present !== 1'b1) begin fails++; $display("FAIL attach_present: got %b want 1", pad_present); end
        tests++; if (rise_last - rise_prev != POLL_T) begin
            fails++; $display("FAIL poll_period: got %0d want %0d", rise_last - rise_prev, POLL_T);
        end
    endtask

    task automatic test_mid_reset();
        bit ok, fd_seen;
        int done_c;
        pad_report = 16'hFFFE;
        ok = 1'b0;
        for (int n = 0; n < 3 * POLL_T; n++) begin
            tick();
            if (joy_strobe) begin ok = 1'b1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL midrst_strobe_timeout: strobe never rose"); end
        repeat (400) tick();
        reset = 1'b1;
        tick();
        tests++; if (joy_strobe !== 1'b0) begin fails++; $display("FAIL midrst_strobe: got %b want 0", joy_strobe); end
        tests++; if (joy_clock !== 1'b1) begin fails++; $display("FAIL midrst_clock: got %b want 1", joy_clock); end
        tests++; if (joystick !== 8'h00) begin fails++; $display("FAIL midrst_joystick: got %h want 00", joystick); end
        fd_seen = frame_done;
        repeat (2) begin tick(); if (frame_done) fd_seen = 1'b1; end
        reset = 1'b0;
        tick();
        tests++; if (joy_strobe !== 1'b1) begin fails++; $display("FAIL midrst_restart: got %b want 1", joy_strobe); end
        done_c = -1;
        for (int c = 2; c <= 1200; c++) begin
            tick();
            if (frame_done) begin done_c = c; break; end
        end
        tests++; if (fd_seen || done_c - 1 < 874 || done_c - 1 > 876) begin
            fails++; $display("FAIL midrst_done: got len %0d early=%b want 875+-1", done_c - 1, fd_seen);
        end
        tests++; if (joystick !== 8'h20) begin fails++; $display("FAIL midrst_b: got %h want 20", joystick); end
        tests++; if (pad_present !== 1'b1) begin fails++; $display("FAIL midrst_present: got %b want 1", pad_present); end
    endtask

    task automatic test_default_period();
        while (def_rise2 < 0 && cyc < 90000) tick();
        tests++; if (def_rise2 - def_rise1 != 69905) begin
            fails++; $display("FAIL default_period: got %0d want 69905", def_rise2 - def_rise1);
        end
        tests++; if (pad_present_def !== 1'b1 || joystick_def !== 8'h00) begin
            fails++; $display("FAIL default_frame: got present=%b joy=%h want 1/00", pad_present_def, joystick_def);
        end
        tests++; if (def_done_cnt != 1 || clock_def !== 1'b1) begin
            fails++; $display("FAIL default_done: got %0d pulses clock=%b want 1/1", def_done_cnt, clock_def);
        end
    endtask

    initial begin
        test_reset();
        test_buttons();
        test_no_pad();
        test_mid_reset();
        test_default_period();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/snes_joy_reader.md
Name: snes_joy_reader

Overview:
- Polls an SNES-protocol game pad over the three-wire latch/clock/data interface at about 60 Hz.
- Converts the 16-bit serial report into the 8-bit active-high button vector consumed by the gb core's `joystick` input.
- Sits directly upstream of the gb core and replaces the undriven joystick register in the top level.
- Runs on clk4 (4.194304 MHz).

Parameters:
- LATCH_CYC, 50: joy_strobe high time in clk cycles (≈12 µs).
- HALF_CYC, 25: duration of each joy_clock half-period in clk cycles (≈6 µs).
- POLL_CYC, 69905: cycles from one frame start to the next (≈60 Hz). Must exceed LATCH_CYC + HALF_CYC + 32*HALF_CYC.

Ports:
- clk  in  1  system clock (clk4).
- reset  in  1  synchronous, active-high reset.
- joy_strobe  out  1  pad latch, active high.
- joy_clock  out  1  pad shift clock; idles high.
- joy_data  in  1  pad serial data, asynchronous, active-low (0 = pressed).
- joystick  out  8  GB buttons, active high: [0] Right, [1] Left, [2] Up, [3] Down, [4] A, [5] B, [6] Select, [7] Start.
- pad_present  out  1  last completed frame carried a valid pad signature.
- frame_done  out  1  one-cycle pulse when joystick/pad_present update.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high (`reset`). All flops update only on posedge clk.
- Reset values: joy_strobe=0, joy_clock=1, joystick=8'h00, pad_present=0, frame_done=0, state=IDLE, poll counter=0, shift register=16'hFFFF, synchronizer flops=1.
- Input synchronizer: joy_data passes through a 2-flop synchronizer. All sampling uses the synchronized value; the 2-cycle delay is negligible against HALF_CYC.
- Poll counter: free-running, 0..POLL_CYC-1, wraps to 0. The frame starts on a wrap, and also on the first cycle after reset deasserts.
- State machine:
  - IDLE: strobe=0, clock=1. Go to LATCH when the poll counter is 0.
  - LATCH: strobe=1 for LATCH_CYC cycles, then go to GAP.
  - GAP: strobe=0, clock=1 for HALF_CYC cycles. On the last cycle, sample bit 0 (B); bit index=1. Go to LOW.
  - LOW: clock=0 for HALF_CYC cycles, then go to HIGH.
  - HIGH: clock=1 for HALF_CYC cycles. On the last cycle, if bit index ≤ 15, sample bit[index]. Increment the index.
    - After the 16th LOW/HIGH pulse (index reaches 16; the 16th pulse has no sample), go to DONE.
    - Otherwise return to LOW.
  - DONE: one cycle. Update outputs, pulse frame_done=1, go to IDLE.
- Serial bit order (raw, active-low), bits 0..15: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R, then four ID bits (12-15).
- pad_present: set to 1 iff raw bits 12..15 == 4'b1111 AND raw bits 0..11 are not all 0.
  - A disconnected line pulled low reads as all zeros and gives 0.
- joystick update in DONE:
  - If pad_present: A = ~A_raw | ~X_raw; B = ~B_raw | ~Y_raw; Select, Start and the four directions = inverted raw bit.
  - L and R are ignored.
  - If not present: joystick = 8'h00.
  - Update is atomic: joystick and pad_present change only in DONE, never mid-frame.
- Opposing directions: if Up and Down are both pressed, both are forced to 0 in joystick. Left and Right are handled the same way.
- Frame length: 50 + 25 + 16*50 = 875 cycles, so the pad is idle for the remaining ≈69030 cycles of each poll period.
- Reset mid-frame: the next cycle returns to IDLE with reset values. The partial shift contents are discarded and joystick does not change except to its reset value.
- Counters hold width ceil(log2(max param)). The poll counter is 17 bits at the default parameters.

Decomposition:
- Shared package/header snes_joy_pkg holds:
  - state encoding IDLE/LATCH/GAP/LOW/HIGH/DONE;
  - SNES raw bit index constants (SNES_B=0 … SNES_R=11, SNES_ID_LO=12);
  - GB joystick bit index constants (GB_RIGHT=0 … GB_START=7).
- One sub-module is natural: joy_sync, the 2-flop synchronizer with reset-to-1.
- Protocol FSM, raw-to-GB mapping and the opposing-direction filter stay in snes_joy_reader.

Test Plan:
- Reset release, pad model returns all bits 1 (nothing pressed):
  - strobe rises on the first cycle after reset release and lasts exactly 50 cycles;
  - exactly 16 clock low pulses, each 25 cycles;
  - frame_done fires 875 cycles ±1 after frame start;
  - joystick=8'h00, pad_present=1.
- Pad presses A and Start (raw 16'b1111_1110_1111_0111 LSB-first in index order: bits 3 and 8 = 0) → joystick=8'h90, pad_present=1.
- Pad presses Up+Down+Left (raw bits 4,5,6=0) → joystick=8'h02 (Left only), pad_present=1.
- joy_data held at 0 (no pad) → joystick=8'h00, pad_present=0.
  - Then the pad is attached with Right pressed → next frame gives joystick=8'h01, pad_present=1.
  - The next strobe starts exactly 69905 cycles after the previous one.
- Reset asserted 400 cycles into a frame with B pressed:
  - the next cycle shows strobe=0, clock=1, joystick=8'h00;
  - no frame_done pulse;
  - a new frame starts the cycle after reset deasserts and yields joystick=8'h20.
- X pressed alone → joystick=8'h10. Y pressed alone → joystick=8'h20. L/R pressed → joystick=8'h00.
